// File: rtl/equsamp_pkg.sv
// -----------------------------------------------------------------------------
// equsamp_pkg
//   Shared definitions for the equivalent-time sampling sequencer:
//   command opcodes, sequencer state encoding (also exported in status_word),
//   status_word field positions and the saturating delay-accumulator add.
// -----------------------------------------------------------------------------
package equsamp_pkg;

    // Command opcodes carried in cmd_in[31:28].
    localparam logic [3:0] OP_SET_STEP  = 4'h1;
    localparam logic [3:0] OP_SET_COUNT = 4'h2;
    localparam logic [3:0] OP_START     = 4'h3;
    localparam logic [3:0] OP_ABORT     = 4'h4;

    // Encoding is visible to software through status_word[31:28].
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ARM   = 4'd1,
        ST_DELAY = 4'd2,
        ST_FIRE  = 4'd3,
        ST_WAIT  = 4'd4,
        ST_DONE  = 4'd5
    } seqState_e;

    // status_word layout.
    localparam int STAT_STATE_LSB = 28;
    localparam int STAT_BUSY      = 27;
    localparam int STAT_DONE      = 26;
    localparam int STAT_TMO       = 25;
    localparam int STAT_INDEX_LSB = 12;
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_FIELD_W   = 12;

    // Unsigned add of two values of 'width' bits (width <= 32) that clamps at
    // all-ones instead of wrapping, so the trigger delay never folds back.
    function automatic logic [31:0] satAdd(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
        logic [32:0] sum;
        logic [32:0] maxVal;
        sum    = {1'b0, a} + {1'b0, b};
        maxVal = (33'd1 << width) - 33'd1;
        return (sum > maxVal) ? maxVal[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/equsamp_seq_ctrl_trig_edge_sync.sv
// -----------------------------------------------------------------------------
// trig_edge_sync
//   Brings the asynchronous external trigger into the clk domain through a
//   two-flop synchronizer and produces a registered one-cycle pulse on each
//   rising edge. The pulse appears 3 clk edges after trigIn rises.
//
// Ports
//   clk      in   sampling clock
//   rest     in   synchronous active-high reset (all flops to 0)
//   trigIn   in   asynchronous trigger input
//   trigEdge out  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module trig_edge_sync (
    input  logic clk,
    input  logic rest,
    input  logic trigIn,
    output logic trigEdge
);

    logic syncMeta;    // first stage, may go metastable
    logic syncStable;  // second stage, safe to use
    logic syncPrev;    // previous synchronized level for edge detection

    // NOTE: non-blocking assignments let every flop sample its pre-edge input, which is what makes this a shift chain.
    always_ff @(posedge clk) begin
        if (rest) begin
            syncMeta   <= 1'b0;
            syncStable <= 1'b0;
            syncPrev   <= 1'b0;
            trigEdge   <= 1'b0;
        end else begin
            syncMeta   <= trigIn;
            syncStable <= syncMeta;
            syncPrev   <= syncStable;
            trigEdge   <= syncStable & ~syncPrev;
        end
    end

endmodule

// File: rtl/equsamp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// equsamp_seq_ctrl
//   Equivalent-time sampling sequencer. Decodes SPI command words, arms on the
//   external trigger and fires one ADC start per trigger at a delay that grows
//   by 'step' clk cycles per sample. Returned samples are written to the
//   capture buffer and a status word is published for SPI readout.
//
// Ports
//   clk          in   sampling clock (single domain)
//   rest         in   synchronous active-high reset
//   cmd_in       in   command word {opcode[31:28], payload[27:0]}
//   cmd_valid    in   one-cycle command strobe
//   trig_in      in   asynchronous external trigger
//   adc_done     in   one-cycle sample-valid pulse
//   adc_data     in   ADC sample
//   adc_start    out  one-cycle conversion start pulse
//   wr_en        out  buffer write strobe (registered)
//   wr_addr      out  buffer write address (registered)
//   wr_data      out  buffer write data (registered)
//   busy         out  acquisition in progress
//   done         out  sticky completion flag
//   status_word  out  {state, busy, done, tmo_err, 0, index, count} (registered)
// -----------------------------------------------------------------------------
module equsamp_seq_ctrl
    import equsamp_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DLY_W   = 24,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rest,
    input  logic [31:0]       cmd_in,
    input  logic              cmd_valid,
    input  logic              trig_in,
    input  logic              adc_done,
    input  logic [15:0]       adc_data,
    output logic              adc_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       status_word
);

    localparam int               TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT - 1);

    seqState_e         state;
    seqState_e         nextState;
    logic [DLY_W-1:0]  step;
    logic [DLY_W-1:0]  acc;
    logic [DLY_W-1:0]  dcnt;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   indexPlusOne;
    logic [TCNT_W-1:0] tcnt;
    logic              tmoErr;
    logic              trigEdge;
    logic              lastSample;
    logic [31:0]       statusNext;

    // ---------------------------------------------------------------- commands
    logic [3:0] cmdOp;
    logic       setStepCmd;
    logic       setCountCmd;
    logic       startCmd;
    logic       abortCmd;
    logic       unusedCmdBits;

    assign cmdOp       = cmd_in[31:28];
    assign setStepCmd  = cmd_valid && (cmdOp == OP_SET_STEP);
    assign setCountCmd = cmd_valid && (cmdOp == OP_SET_COUNT);
    assign startCmd    = cmd_valid && (cmdOp == OP_START);
    assign abortCmd    = cmd_valid && (cmdOp == OP_ABORT);
    // Payload bits beyond the step/count fields carry no meaning.
    assign unusedCmdBits = ^cmd_in[27:0];

    // ---------------------------------------------------------------- trigger
    trig_edge_sync uTrigSync (
        .clk      (clk),
        .rest     (rest),
        .trigIn   (trig_in),
        .trigEdge (trigEdge)
    );

    // Extended by one bit so index+1 never wraps before the compare.
    assign indexPlusOne = {1'b0, index} + {{ADDR_W{1'b0}}, 1'b1};
    assign lastSample   = (indexPlusOne == {1'b0, count});

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rest) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: nextState gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (startCmd) begin
                    nextState = (count == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (trigEdge) begin
                    nextState = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dcnt == '0) begin
                    nextState = ST_FIRE;
                end
            end
            ST_FIRE: begin
                nextState = ST_WAIT;
            end
            ST_WAIT: begin
                // A sample arriving on the timeout cycle still counts.
                if (adc_done) begin
                    nextState = lastSample ? ST_DONE : ST_ARM;
                end else if (tcnt == TMO_LAST) begin
                    nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
        if (abortCmd) begin
            nextState = ST_IDLE;
        end
    end

    // FIRE is a single state, so the start pulse is exactly one cycle wide and
    // comes straight from the state register.
    assign adc_start = (state == ST_FIRE);
    assign busy      = (state != ST_IDLE);

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rest) begin
            step        <= DLY_W'(1);
            count       <= '0;
            index       <= '0;
            acc         <= '0;
            dcnt        <= '0;
            tcnt        <= '0;
            tmoErr      <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            status_word <= '0;
        end else begin
            wr_en       <= 1'b0;
            status_word <= statusNext;
            // ABORT freezes the datapath: index stays readable, no write
            // escapes and done keeps its previous value.
            if (!abortCmd) begin
                case (state)
                    ST_IDLE: begin
                        if (setStepCmd) begin
                            step <= cmd_in[DLY_W-1:0];
                        end
                        if (setCountCmd) begin
                            count <= cmd_in[ADDR_W-1:0];
                        end
                        if (startCmd && (count != '0)) begin
                            index  <= '0;
                            acc    <= '0;
                            done   <= 1'b0;
                            tmoErr <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (trigEdge) begin
                            dcnt <= acc;
                        end
                    end
                    ST_DELAY: begin
                        if (dcnt != '0) begin
                            dcnt <= dcnt - DLY_W'(1);
                        end
                    end
                    ST_FIRE: begin
                        tcnt <= '0;
                    end
                    ST_WAIT: begin
                        if (adc_done) begin
                            wr_en   <= 1'b1;
                            wr_addr <= index;
                            wr_data <= adc_data;
                            index   <= indexPlusOne[ADDR_W-1:0];
                            acc     <= DLY_W'(satAdd(32'(acc), 32'(step), DLY_W));
                        end else if (tcnt == TMO_LAST) begin
                            tmoErr <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        statusNext = '0;
        statusNext[STAT_STATE_LSB +: 4]            = state;
        statusNext[STAT_BUSY]                      = busy;
        statusNext[STAT_DONE]                      = done;
        statusNext[STAT_TMO]                       = tmoErr;
        statusNext[STAT_INDEX_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(index);
        statusNext[STAT_COUNT_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(count);
    end

endmodule

// File: tb/tb_equsamp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_equsamp_seq_ctrl
//   Directed bench for equsamp_seq_ctrl. Stimulus pushes the expected ADC start
//   cycles and buffer writes into queues; a monitor pops and compares whenever
//   the DUT raises adc_start or wr_en. A small ADC responder answers each start
//   with adc_done five cycles later. DLY_W is reduced to 10 so the saturation
//   case completes in a few thousand cycles.
// -----------------------------------------------------------------------------
module tb_equsamp_seq_ctrl;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wrExp_t;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] cmd_in;
    logic        cmd_valid;
    logic        trig_in;
    logic        adc_done;
    logic [15:0] adc_data;
    logic        adc_start;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] status_word;

    int     cyc = 0;
    int     nCmp = 0;
    int     nMis = 0;
    int     expStartQ[$];
    wrExp_t expWrQ[$];

    bit          respEn = 1'b0;
    logic [15:0] respBase = 16'h0000;
    int          respCnt = 0;
    int          pend = 0;

    int trigCyc;
    int xCyc;
    int waited;

    equsamp_seq_ctrl #(
        .ADDR_W  (12),
        .DLY_W   (10),
        .TIMEOUT (1024)
    ) dut (
        .clk         (clk),
        .rest        (rest),
        .cmd_in      (cmd_in),
        .cmd_valid   (cmd_valid),
        .trig_in     (trig_in),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .adc_start   (adc_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .status_word (status_word)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [3:0] op, input logic [27:0] payload);
        @(posedge clk);
        #1;
        cmd_in    = {op, payload};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_in    = '0;
    endtask

    // Trigger high for three cycles starting in cycle riseCyc; returns in riseCyc+3.
    task automatic pulseTrig(output int riseCyc);
        @(posedge clk);
        #1;
        riseCyc = cyc;
        trig_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        trig_in = 1'b0;
    endtask

    // Start expected 5 + delay cycles after the trigger rise cycle
    // (3 sync/edge + 1 DELAY entry + delay decrements + 1 FIRE).
    task automatic sample(input int delay, input bit expectStart);
        int n;
        pulseTrig(n);
        if (expectStart) expStartQ.push_back(n + 5 + delay);
        idle(delay + 14);
    endtask

    task automatic newTest(input logic [15:0] base, input bit en);
        respBase = base;
        respCnt  = 0;
        respEn   = en;
    endtask

    // ADC responder: adc_done five cycles after each observed start.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_done = 1'b1;
                    adc_data = respBase + 16'(respCnt * 4);
                    respCnt++;
                end
            end
            if (adc_start && respEn) pend = 5;
        end
    end

    // Monitor: compares DUT output events against the scoreboard queues.
    initial begin
        int e;
        wrExp_t w;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                if (expStartQ.size() == 0) begin
                    nCmp++;
                    nMis++;
                    $display("FAIL adc_start_unexpected: got start at cycle %0d, required none", cyc);
                end else begin
                    e = expStartQ.pop_front();
                    check("adc_start_cycle", 32'(cyc), 32'(e));
                end
            end
            if (wr_en === 1'b1) begin
                if (expWrQ.size() == 0) begin
                    nCmp++;
                    nMis++;
                    $display("FAIL write_unexpected: got addr 0x%03h data 0x%04h, required no write", wr_addr, wr_data);
                end else begin
                    w = expWrQ.pop_front();
                    check("write_addr_data", {4'h0, wr_addr, wr_data}, {4'h0, w.addr, w.data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rest      = 1'b1;
        cmd_in    = '0;
        cmd_valid = 1'b0;
        trig_in   = 1'b0;
        idle(3);
        rest = 1'b0;

        // Reset state.
        check("rst_adc_start", 32'(adc_start), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_status", status_word, 32'h0000_0000);

        // Four samples, step 10.
        newTest(16'hA000, 1'b1);
        sendCmd(4'h1, 28'd10);
        sendCmd(4'h2, 28'd4);
        expWrQ.push_back('{12'd0, 16'hA000});
        expWrQ.push_back('{12'd1, 16'hA004});
        expWrQ.push_back('{12'd2, 16'hA008});
        expWrQ.push_back('{12'd3, 16'hA00C});
        sendCmd(4'h3, 28'd0);
        check("t1_busy_armed", 32'(busy), 1);
        for (int k = 0; k < 4; k++) sample(10 * k, 1'b1);
        idle(4);
        check("t1_busy", 32'(busy), 0);
        check("t1_done", 32'(done), 1);
        check("t1_status", status_word, 32'h0400_4004);

        // Count zero: straight through DONE.
        sendCmd(4'h2, 28'd0);
        sendCmd(4'h3, 28'd0);
        check("t2_busy_in_done", 32'(busy), 1);
        idle(1);
        check("t2_busy", 32'(busy), 0);
        check("t2_done", 32'(done), 1);
        idle(3);
        check("t2_status", status_word, 32'h0400_4000);

        // Timeout on the second sample.
        newTest(16'hB000, 1'b1);
        sendCmd(4'h2, 28'd3);
        expWrQ.push_back('{12'd0, 16'hB000});
        sendCmd(4'h3, 28'd0);
        sample(0, 1'b1);
        respEn = 1'b0;
        pulseTrig(trigCyc);
        expStartQ.push_back(trigCyc + 15);
        waited = 0;
        while (done !== 1'b1 && waited < 1200) begin
            idle(1);
            waited++;
        end
        check("t3_done_within_bound", 32'(waited < 1200), 1);
        idle(4);
        check("t3_busy", 32'(busy), 0);
        check("t3_status", status_word, 32'h0600_1003);

        // ABORT in the DELAY of sample 2.
        newTest(16'hC000, 1'b1);
        sendCmd(4'h2, 28'd4);
        expWrQ.push_back('{12'd0, 16'hC000});
        expWrQ.push_back('{12'd1, 16'hC004});
        sendCmd(4'h3, 28'd0);
        sample(0, 1'b1);
        sample(10, 1'b1);
        pulseTrig(trigCyc);
        idle(4);
        sendCmd(4'h4, 28'd0);
        check("t4_busy_after_abort", 32'(busy), 0);
        idle(40);
        check("t4_status", status_word, 32'h0000_2004);

        // Saturating accumulator: all-ones step.
        newTest(16'hD000, 1'b1);
        sendCmd(4'h1, 28'h3FF);
        sendCmd(4'h2, 28'd3);
        expWrQ.push_back('{12'd0, 16'hD000});
        expWrQ.push_back('{12'd1, 16'hD004});
        expWrQ.push_back('{12'd2, 16'hD008});
        sendCmd(4'h3, 28'd0);
        sample(0, 1'b1);
        sample(1023, 1'b1);
        sample(1023, 1'b1);
        idle(4);
        check("t5_status", status_word, 32'h0400_3003);

        // Extra triggers and SET_STEP while busy are ignored.
        newTest(16'hE000, 1'b1);
        sendCmd(4'h1, 28'd10);
        sendCmd(4'h2, 28'd2);
        expWrQ.push_back('{12'd0, 16'hE000});
        expWrQ.push_back('{12'd1, 16'hE004});
        sendCmd(4'h3, 28'd0);
        sendCmd(4'h1, 28'd3);
        sample(0, 1'b1);
        pulseTrig(trigCyc);
        expStartQ.push_back(trigCyc + 15);
        pulseTrig(xCyc);               // edge lands in DELAY
        idle(trigCyc + 13 - cyc);
        pulseTrig(xCyc);               // edge lands in WAIT
        idle(20);
        check("t6_done", 32'(done), 1);
        check("t6_status", status_word, 32'h0400_2002);

        // Reset in the middle of WAIT.
        newTest(16'hF000, 1'b0);
        sendCmd(4'h3, 28'd0);
        pulseTrig(trigCyc);
        expStartQ.push_back(trigCyc + 5);
        idle(4);
        rest = 1'b1;
        idle(1);
        rest = 1'b0;
        check("r_adc_start", 32'(adc_start), 0);
        check("r_wr_en", 32'(wr_en), 0);
        check("r_wr_addr", 32'(wr_addr), 0);
        check("r_wr_data", 32'(wr_data), 0);
        check("r_busy", 32'(busy), 0);
        check("r_done", 32'(done), 0);
        check("r_status", status_word, 32'h0000_0000);
        idle(10);

        check("start_queue_empty", 32'(expStartQ.size()), 0);
        check("write_queue_empty", 32'(expWrQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
